// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
//
// Runs one arithmetic operation for a keypad calculator. The number-entry
// block delivers two operands. A keypad operator key then starts an add,
// subtract, multiply or divide. Add and subtract finish in one cycle.
// Multiply (shift-add) and divide (restoring) each take 16 iterations, one
// per cycle. The result stays held until the next operation completes.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous active-low reset
//   num_a, num_b   in  16   operands, captured on operands_valid
//   operands_valid in   1   one-cycle pulse qualifying num_a/num_b
//   entry_value    in  16   digits being typed, shown in IDLE/ARMED
//   key            in   4   keypad code
//   key_load       in   1   one-cycle pulse qualifying key
//   result         out 16   operation result
//   remainder      out 16   division remainder (0 for other operations)
//   busy           out  1   high while an operation is executing
//   done           out  1   one-cycle completion pulse
//   ovf            out  1   carry / borrow / product-overflow flag
//   err            out  1   divide-by-zero flag
//   disp_value     out 16   value routed to the display driver
// ---------------------------------------------------------------------------
module calc_sequencer #(
    parameter logic [3:0] K_ADD = 4'hD,
    parameter logic [3:0] K_SUB = 4'hE,
    parameter logic [3:0] K_MUL = 4'hF,
    parameter logic [3:0] K_DIV = 4'hA,
    parameter logic [3:0] K_DEL = 4'hC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] num_a,
    input  logic [15:0] num_b,
    input  logic        operands_valid,
    input  logic [15:0] entry_value,
    input  logic [3:0]  key,
    input  logic        key_load,
    output logic [15:0] result,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        err,
    output logic [15:0] disp_value
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] result_q, result_d;
    logic [15:0] rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    // Iteration datapath, shared by multiply and divide.
    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    logic [16:0] mul_sum;
    logic [31:0] mul_step;
    logic [16:0] div_trial;
    logic [15:0] div_diff;
    logic        div_take;
    logic [31:0] div_step;
    logic [16:0] add_sum;
    logic [4:0]  cnt_inc;
    logic        last_iter;

    always_comb begin
        mul_sum   = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, a_q} : 17'd0);
        mul_step  = {mul_sum, acc_q[15:1]};

        // The trial value is below 2*B, so when it is at least B the
        // difference fits in 16 bits and only the low half is needed.
        div_trial = acc_q[31:15];
        div_take  = (div_trial >= {1'b0, b_q});
        div_diff  = div_trial[15:0] - b_q;
        div_step  = div_take ? {div_diff, acc_q[14:0], 1'b1}
                             : {div_trial[15:0], acc_q[14:0], 1'b0};

        add_sum   = {1'b0, a_q} + {1'b0, b_q};

        // The counter saturates at 16 and never wraps.
        cnt_inc   = (cnt_q >= 5'd16) ? 5'd16 : cnt_q + 5'd1;
        last_iter = (cnt_q == 5'd15);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (operands_valid) begin
                    a_d     = num_a;
                    b_d     = num_b;
                    state_d = S_ARMED;
                end
            end

            S_ARMED: begin
                if (key_load) begin
                    if (key == K_ADD || key == K_SUB ||
                        key == K_MUL || key == K_DIV) begin
                        if (key == K_ADD)      op_d = OP_ADD;
                        else if (key == K_SUB) op_d = OP_SUB;
                        else if (key == K_MUL) op_d = OP_MUL;
                        else                   op_d = OP_DIV;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b0;
                        // Multiply iterates over B's bits; divide over A's.
                        acc_d   = (key == K_DIV) ? {16'h0000, a_q}
                                                 : {16'h0000, b_q};
                        state_d = S_EXEC;
                    end else if (key == K_DEL) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        result_d = add_sum[15:0];
                        rem_d    = '0;
                        ovf_d    = add_sum[16];
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                    OP_SUB: begin
                        result_d = a_q - b_q;
                        rem_d    = '0;
                        ovf_d    = (a_q < b_q);
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                    OP_MUL: begin
                        acc_d = mul_step;
                        cnt_d = cnt_inc;
                        if (last_iter) begin
                            result_d = mul_step[15:0];
                            rem_d    = '0;
                            ovf_d    = |mul_step[31:16];
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end
                    end
                    OP_DIV: begin
                        if (b_q == 16'h0000) begin
                            result_d = '1;
                            rem_d    = a_q;
                            ovf_d    = 1'b0;
                            err_d    = 1'b1;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            acc_d = div_step;
                            cnt_d = cnt_inc;
                            if (last_iter) begin
                                result_d = div_step[15:0];
                                rem_d    = div_step[31:16];
                                ovf_d    = 1'b0;
                                done_d   = 1'b1;
                                state_d  = S_DONE;
                            end
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            S_DONE: begin
                // A new operand pair takes precedence over a delete key.
                if (operands_valid) begin
                    a_d     = num_a;
                    b_d     = num_b;
                    state_d = S_ARMED;
                end else if (key_load && key == K_DEL) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        result    = result_q;
        remainder = rem_q;
        ovf       = ovf_q;
        err       = err_q;
        done      = done_q;
        busy      = (state_q == S_EXEC);
        case (state_q)
            S_EXEC:  disp_value = a_q;
            S_DONE:  disp_value = result_q;
            default: disp_value = entry_value;
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

    localparam logic [3:0] K_ADD = 4'hD;
    localparam logic [3:0] K_SUB = 4'hE;
    localparam logic [3:0] K_MUL = 4'hF;
    localparam logic [3:0] K_DIV = 4'hA;
    localparam logic [3:0] K_DEL = 4'hC;
    localparam logic [15:0] ENTRY = 16'h1234;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] num_a, num_b, entry_value;
    logic        operands_valid;
    logic [3:0]  key;
    logic        key_load;
    logic [15:0] result, remainder, disp_value;
    logic        busy, done, ovf, err;

    int errors = 0;
    int checks = 0;
    logic [15:0] prev_result = 16'h0000;

    always #5 clk = ~clk;

    calc_sequencer #(
        .K_ADD(K_ADD), .K_SUB(K_SUB), .K_MUL(K_MUL), .K_DIV(K_DIV), .K_DEL(K_DEL)
    ) dut (
        .clk(clk), .rst(rst),
        .num_a(num_a), .num_b(num_b), .operands_valid(operands_valid),
        .entry_value(entry_value), .key(key), .key_load(key_load),
        .result(result), .remainder(remainder), .busy(busy), .done(done),
        .ovf(ovf), .err(err), .disp_value(disp_value)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  k;
        logic [15:0] res;
        logic [15:0] rem;
        logic        ovf;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // All helpers start and end on a falling edge.
    task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
        num_a = a; num_b = b; operands_valid = 1'b1;
        @(negedge clk);
        operands_valid = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        key = k; key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Called just after the acceptance edge; waits (bounded) for done.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0; busy_n = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int lat, busy_n;
        load_ops(v.a, v.b);
        chk({tag, " armed disp"}, disp_value, ENTRY);
        press(v.k);
        chk({tag, " busy after accept"}, busy, 1'b1);
        chk({tag, " flags cleared ovf"}, ovf, 1'b0);
        chk({tag, " flags cleared err"}, err, 1'b0);
        chk({tag, " result held"}, result, prev_result);
        chk({tag, " exec disp"}, disp_value, v.a);
        wait_done(lat, busy_n);
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " busy cycles"}, busy_n, v.lat);
        chk({tag, " result"}, result, v.res);
        chk({tag, " remainder"}, remainder, v.rem);
        chk({tag, " ovf"}, ovf, v.ovf);
        chk({tag, " err"}, err, v.err);
        chk({tag, " done disp"}, disp_value, v.res);
        @(negedge clk);
        chk({tag, " done one cycle"}, done, 1'b0);
        chk({tag, " idle in DONE"}, busy, 1'b0);
        chk({tag, " result hold"}, result, v.res);
        prev_result = v.res;
    endtask

    initial begin
        int lat, busy_n, dones;
        vec_t v;

        vecs[0]  = '{16'd12,    16'd7,     K_ADD, 16'd19,    16'd0, 1'b0, 1'b0, 1};
        vecs[1]  = '{16'd300,   16'd500,   K_SUB, 16'hFF38,  16'd0, 1'b1, 1'b0, 1};
        vecs[2]  = '{16'd1234,  16'd56,    K_MUL, 16'd3568,  16'd0, 1'b1, 1'b0, 16};
        vecs[3]  = '{16'd100,   16'd7,     K_DIV, 16'd14,    16'd2, 1'b0, 1'b0, 16};
        vecs[4]  = '{16'd9,     16'd0,     K_DIV, 16'hFFFF,  16'd9, 1'b0, 1'b1, 1};
        vecs[5]  = '{16'hFFFF,  16'd1,     K_ADD, 16'd0,     16'd0, 1'b1, 1'b0, 1};
        vecs[6]  = '{16'd255,   16'd255,   K_MUL, 16'hFE01,  16'd0, 1'b0, 1'b0, 16};
        vecs[7]  = '{16'hFFFF,  16'hFFFF,  K_DIV, 16'd1,     16'd0, 1'b0, 1'b0, 16};
        vecs[8]  = '{16'd5,     16'd5,     K_SUB, 16'd0,     16'd0, 1'b0, 1'b0, 1};
        vecs[9]  = '{16'd7,     16'd100,   K_DIV, 16'd0,     16'd7, 1'b0, 1'b0, 16};
        vecs[10] = '{16'd0,     16'hFFFF,  K_MUL, 16'd0,     16'd0, 1'b0, 1'b0, 16};

        rst = 1'b0; num_a = '0; num_b = '0; operands_valid = 1'b0;
        entry_value = ENTRY; key = '0; key_load = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset result", result, 16'd0);
        chk("reset remainder", remainder, 16'd0);
        chk("reset flags", {busy, done, ovf, err}, 4'b0000);
        chk("reset disp", disp_value, ENTRY);
        rst = 1'b1;
        @(negedge clk);

        // Keys are ignored in IDLE.
        press(K_ADD);
        repeat (3) @(negedge clk);
        chk("idle ignores key busy", busy, 1'b0);
        chk("idle ignores key done", done, 1'b0);

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // DONE: operands_valid and K_DEL together -> ARMED with new operands.
        num_a = 16'd20; num_b = 16'd22; operands_valid = 1'b1;
        key = K_DEL; key_load = 1'b1;
        @(negedge clk);
        operands_valid = 1'b0; key_load = 1'b0;
        chk("simul disp armed", disp_value, ENTRY);
        chk("simul not busy", busy, 1'b0);
        press(K_ADD);
        wait_done(lat, busy_n);
        chk("simul add latency", lat, 1);
        chk("simul add result", result, 16'd42);
        prev_result = 16'd42;
        @(negedge clk);

        // ARMED: K_DEL returns to IDLE, so a following operator is ignored.
        load_ops(16'd1, 16'd2);
        press(K_DEL);
        press(K_ADD);
        repeat (2) @(negedge clk);
        chk("del to idle busy", busy, 1'b0);
        chk("del to idle result", result, 16'd42);

        // key_load/operands_valid during EXEC change neither result nor timing.
        load_ops(16'd1000, 16'd3);
        press(K_MUL);
        lat = 0; busy_n = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            if (lat == 3) begin key = K_DEL; key_load = 1'b1; end
            else if (lat == 5) begin
                key = K_ADD; key_load = 1'b1;
                num_a = 16'd7; num_b = 16'd7; operands_valid = 1'b1;
            end else begin
                key_load = 1'b0; operands_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        key_load = 1'b0; operands_valid = 1'b0;
        chk("exec keys latency", lat, 16);
        chk("exec keys busy", busy_n, 16);
        chk("exec keys result", result, 16'd3000);
        chk("exec keys ovf", ovf, 1'b0);
        @(negedge clk);
        prev_result = 16'd3000;

        // Reset at edge k+5 of a multiply aborts it with no done.
        load_ops(16'd1234, 16'd56);
        press(K_MUL);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort result", result, 16'd0);
        chk("abort remainder", remainder, 16'd0);
        chk("abort flags", {ovf, err}, 2'b00);
        chk("abort disp", disp_value, ENTRY);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("abort no done", dones, 0);
        prev_result = 16'd0;
        v = '{16'd3, 16'd4, K_MUL, 16'd12, 16'd0, 1'b0, 1'b0, 16};
        do_op(v, "post-abort mul");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
